mem_arbiter: RTL and testbench

Shares the CPU's single unified memory port between instruction fetch and the load/store unit. Each requester holds a request until it receives a one-cycle done pulse. The arbiter sequences one memory transaction at a time through a small FSM and grants round-robin on conflict. It sits between the PC/fetch block, the execute/register-file block and the memory, and its busy state is the source of pipeline stall.

---
 rtl/cpu_pkg.sv | 6 +
 rtl/mem_arbiter.sv | 87 ++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the memory-port arbiter.
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} arb_owner_t;
  localparam logic [3:0] BE_WORD = 4'b1111;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of the single memory port between fetch and load/store.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_be,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);
  arb_state_t            r_state;
  arb_owner_t            r_owner;
  arb_owner_t            r_last;
  logic                  r_we;
  logic [3:0]            r_be;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;
  logic                  w_pick_d;
  arb_owner_t            w_own;
  // on a tie, data wins unless it won last time
  assign w_pick_d = d_req && (!if_req || r_last == OWN_FETCH);
  assign w_own    = w_pick_d ? OWN_DATA : OWN_FETCH;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_owner    <= OWN_FETCH;
      r_last     <= OWN_FETCH;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: if (if_req || d_req) begin
          r_state <= ISSUE;
          r_owner <= w_own;
          r_last  <= w_own;
          r_we    <= w_pick_d ? d_we : 1'b0;
          r_be    <= w_pick_d ? d_be : BE_WORD;
          r_addr  <= w_pick_d ? d_addr : if_addr;
          r_wdata <= w_pick_d ? d_wdata : '0;
        end
        ISSUE: if (mem_ready) r_state <= WAIT;
        WAIT: if (mem_rvalid) begin
          r_state <= RESP;
          if (!r_we && r_owner == OWN_FETCH) r_if_rdata <= mem_rdata;
          if (!r_we && r_owner == OWN_DATA) r_d_rdata <= mem_rdata;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign mem_valid = r_state == ISSUE;
  assign busy      = r_state != IDLE;
  assign if_done   = r_state == RESP && r_owner == OWN_FETCH;
  assign d_done    = r_state == RESP && r_owner == OWN_DATA;
  assign mem_we    = r_we;
  assign mem_be    = r_be;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with an inline memory responder.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  typedef struct {logic own_d; logic [31:0] data;} exp_t;
  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  bit          mem_en = 1'b1;
  int          stall = 0;
  bit          acc = 1'b0;
  logic [31:0] rsp = '0;
  logic [31:0] mem_model [logic [31:0]];

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one cycle; when enabled, also plays the memory: ready after `stall` cycles, response one cycle later
  task automatic tick();
    logic [31:0] w;
    @(negedge clk);
    if (mem_en) begin
      mem_rvalid = 1'b0;
      if (acc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rsp;
        acc        = 1'b0;
      end
      if (mem_valid && stall > 0) begin
        mem_ready = 1'b0;
        stall--;
      end else if (mem_valid && !mem_ready) begin
        mem_ready = 1'b1;
        acc       = 1'b1;
        w = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
        if (mem_we) begin
          for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
          mem_model[mem_addr] = w;
          rsp = 32'hFFFF_FFFF;
        end else rsp = w;
      end else mem_ready = 1'b0;
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) tick();
    chk("done_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // scoreboard monitor: every done pulse pops one expected completion
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (if_done === 1'b1 || d_done === 1'b1) begin
      chk("dual_done", 32'(if_done & d_done), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_done: observed if_done=%b d_done=%b expected none", if_done, d_done);
      end else begin
        e = sb.pop_front();
        chk("owner_d", 32'(d_done), 32'(e.own_d));
        chk("rdata", d_done ? d_rdata : if_rdata, e.data);
      end
      done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    mem_model[32'h10]  = 32'h0050_0093;
    mem_model[32'h200] = 32'hCAFE_0001;
    do_reset();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(mem_valid), 0);
    chk("rst_fields", {mem_we, mem_be, 27'd0}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", if_rdata | d_rdata, 0);
    chk("rst_done", 32'({if_done, d_done}), 0);

    // single fetch, minimum latency
    if_addr = 32'h10;
    if_req  = 1'b1;
    sb.push_back('{1'b0, 32'h0050_0093});
    tick();
    chk("f_valid_n1", 32'(mem_valid), 1);
    chk("f_addr", mem_addr, 32'h10);
    chk("f_we_be", {27'd0, mem_we, mem_be}, 32'h0F);
    tick();
    chk("f_valid_n2", 32'(mem_valid), 0);
    chk("f_done_n2", 32'(if_done), 0);
    tick();
    chk("f_done_n3", 32'(if_done), 1);
    if_req = 1'b0;
    tick();
    chk("f_done_n4", 32'(if_done), 0);
    chk("f_busy_n4", 32'(busy), 0);
    chk("f_rdata", if_rdata, 32'h0050_0093);

    // stray handshake in IDLE
    mem_en = 1'b0;
    mem_ready = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    tick();
    tick();
    chk("stray_busy", 32'(busy), 0);
    chk("stray_valid", 32'(mem_valid), 0);
    chk("stray_rdata", if_rdata, 32'h0050_0093);
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_en = 1'b1;

    // contention from reset: D, F, D, F
    do_reset();
    base = done_cnt;
    if_addr = 32'h10;
    d_we = 1'b0;
    d_addr = 32'h200;
    if_req = 1'b1;
    d_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{1'b1, 32'hCAFE_0001});
      sb.push_back('{1'b0, 32'h0050_0093});
    end
    wait_done(base + 4, 40);
    if_req = 1'b0;
    d_req = 1'b0;
    tick();
    tick();
    chk("cont_count", 32'(done_cnt - base), 4);
    chk("cont_busy", 32'(busy), 0);

    // store leaves d_rdata unchanged
    base = done_cnt;
    d_we = 1'b1;
    d_be = 4'b0011;
    d_addr = 32'h100;
    d_wdata = 32'hDEAD_BEEF;
    d_req = 1'b1;
    sb.push_back('{1'b1, 32'hCAFE_0001});
    tick();
    chk("st_valid", 32'(mem_valid), 1);
    chk("st_we_be", {27'd0, mem_we, mem_be}, 32'h13);
    chk("st_addr", mem_addr, 32'h100);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    wait_done(base + 1, 10);
    d_req = 1'b0;
    tick();
    chk("st_mem", mem_model[32'h100], 32'h0000_BEEF);

    // back-pressure: three stalled cycles in ISSUE, request fields change after grant
    base = done_cnt;
    stall = 3;
    d_we = 1'b0;
    d_be = 4'b0000;
    d_addr = 32'h200;
    d_req = 1'b1;
    sb.push_back('{1'b1, 32'hCAFE_0001});
    for (int i = 1; i <= 4; i++) begin
      tick();
      d_addr = 32'h999;
      chk("bp_valid", 32'(mem_valid), 1);
      chk("bp_addr", mem_addr, 32'h200);
      chk("bp_be", 32'(mem_be), 32'h0);
    end
    tick();
    chk("bp_valid_off", 32'(mem_valid), 0);
    tick();
    chk("bp_done_n6", 32'(d_done), 1);
    d_req = 1'b0;
    tick();
    chk("bp_count", 32'(done_cnt - base), 1);

    // reset during WAIT, then a stray response
    mem_en = 1'b0;
    if_req = 1'b1;
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("rw_wait_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_req = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h1234;
    tick();
    mem_rvalid = 1'b0;
    tick();
    chk("rw_busy", 32'(busy), 0);
    chk("rw_valid", 32'(mem_valid), 0);
    chk("rw_done", 32'({if_done, d_done}), 0);
    chk("rw_if_rdata", if_rdata, 0);
    chk("rw_d_rdata", d_rdata, 0);
    mem_en = 1'b1;
    tick();
    tick();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
